// File: rtl/scanconvert2_lx45_pkg.sv
// scanconvert2_lx45_pkg: shared widths, timing defaults and sync polarity for the scan converter
package scanconvert2_lx45_pkg;
   localparam int RGB_W      = 8;
   localparam int MAX_PIX    = 512;
   localparam int HS_O       = 96;
   localparam int HBP_O      = 48;
   localparam int PIX_CLKS_O = 2;
   localparam logic SYNC_ACT  = 1'b0;
   localparam logic SYNC_IDLE = 1'b1;
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/scanconv_linebuf.sv
// scanconv_linebuf: simple dual-port RAM, one write port and one registered read port on one clock
module scanconv_linebuf #(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_q;
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_q <= r_mem[i_raddr];
   end
   assign o_rdata = r_q;
endmodule

// File: rtl/scanconvert2_lx45.sv
// scanconvert2_lx45: line-doubling scan converter; each input line is stored in a ping-pong
// buffer and replayed twice at double pixel rate during the following input line
module scanconvert2_lx45 #(
   parameter int MAX_PIX    = scanconvert2_lx45_pkg::MAX_PIX,
   parameter int HS_O       = scanconvert2_lx45_pkg::HS_O,
   parameter int HBP_O      = scanconvert2_lx45_pkg::HBP_O,
   parameter int PIX_CLKS_O = scanconvert2_lx45_pkg::PIX_CLKS_O
) (
   input  logic                                  clk25m,
   input  logic                                  reset,
   input  logic                                  pix_ce_i,
   input  logic                                  hsync_i,
   input  logic                                  vsync_i,
   input  logic                                  blank_i,
   input  logic [scanconvert2_lx45_pkg::RGB_W-1:0] rgb_i,
   output logic                                  hsync_o,
   output logic                                  vsync_o,
   output logic                                  blank_o,
   output logic [scanconvert2_lx45_pkg::RGB_W-1:0] rgb_o
);
   import scanconvert2_lx45_pkg::*;
   localparam int AW = $clog2(MAX_PIX);
   logic             r_hs_prev, r_sel, r_second, r_seen, r_primed;
   logic [AW-1:0]    r_wx, r_len;
   logic [15:0]      r_cnt, r_period, r_ox;
   logic             r_vs, r_act1, r_hs1, r_vs1;
   logic             w_ls, w_we, w_wrap, w_act, w_hs, w_vs;
   logic [15:0]      w_half, w_off;
   logic [16:0]      w_end;
   logic [AW:0]      w_waddr, w_raddr;
   logic [RGB_W-1:0] w_q;
   assign w_ls    = pix_ce_i & ~hsync_i & r_hs_prev;
   assign w_we    = pix_ce_i & ~blank_i;
   // the pixel on a line-start strobe already belongs to the new line
   assign w_waddr = w_ls ? {~r_sel, {AW{1'b0}}} : {r_sel, r_wx};
   assign w_half  = r_period >> 1;
   assign w_wrap  = !r_second && w_half != 16'd0 && r_ox == w_half - 16'd1;
   assign w_end   = 17'(HBP_O) + 17'(r_len) * 17'(PIX_CLKS_O);
   assign w_act   = r_primed && r_ox >= 16'(HBP_O) && {1'b0, r_ox} < w_end;
   assign w_off   = r_ox - 16'(HBP_O);
   assign w_raddr = {~r_sel, AW'(w_off / 16'(PIX_CLKS_O))};
   assign w_hs    = (r_primed && r_ox < 16'(HS_O)) ? SYNC_ACT : SYNC_IDLE;
   assign w_vs    = r_primed ? r_vs : SYNC_IDLE;
   scanconv_linebuf #(.AW(AW + 1), .DW(RGB_W)) u_buf (
      .i_clk   (clk25m),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (rgb_i),
      .i_raddr (w_raddr),
      .o_rdata (w_q)
   );
   always_ff @(posedge clk25m or negedge reset) begin
      if (!reset) begin
         r_hs_prev <= 1'b1;
         r_sel     <= 1'b0;
         r_second  <= 1'b0;
         r_seen    <= 1'b0;
         r_primed  <= 1'b0;
         r_wx      <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_period  <= '0;
         r_ox      <= '0;
         r_vs      <= SYNC_IDLE;
         r_act1    <= 1'b0;
         r_hs1     <= SYNC_IDLE;
         r_vs1     <= SYNC_IDLE;
         hsync_o   <= SYNC_IDLE;
         vsync_o   <= SYNC_IDLE;
         blank_o   <= 1'b1;
         rgb_o     <= '0;
      end else begin
         r_cnt <= w_ls ? 16'd1 : sat_inc16(r_cnt);
         if (pix_ce_i) begin
            r_hs_prev <= hsync_i;
            r_vs      <= vsync_i;
         end
         if (w_ls) begin
            r_len    <= r_wx;
            r_wx     <= w_we ? AW'(1) : '0;
            r_sel    <= ~r_sel;
            r_period <= r_cnt;
            r_ox     <= '0;
            r_second <= 1'b0;
            r_seen   <= 1'b1;
            if (r_seen) r_primed <= 1'b1;
         end else begin
            if (w_we && r_wx != AW'(MAX_PIX - 1)) r_wx <= r_wx + AW'(1);
            r_ox <= w_wrap ? '0 : sat_inc16(r_ox);
            if (w_wrap) r_second <= 1'b1;
         end
         // two-stage output pipe matches the RAM read latency
         r_act1  <= w_act;
         r_hs1   <= w_hs;
         r_vs1   <= w_vs;
         hsync_o <= r_hs1;
         vsync_o <= r_vs1;
         blank_o <= ~r_act1;
         rgb_o   <= r_act1 ? w_q : '0;
      end
   end
endmodule

// File: tb/tb_scanconvert2_lx45.sv
// tb_scanconvert2_lx45: directed line-doubler scenarios checked against hand-computed output timing
module tb_scanconvert2_lx45;
   localparam int N = 20000;
   typedef struct { int off; logic hs; logic bl; logic [7:0] rgb; } vec_t;
   logic clk25m = 1'b0, reset = 1'b0, pix_ce_i = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1, blank_i = 1'b1;
   logic [7:0] rgb_i = 8'h00;
   logic hsync_o, vsync_o, blank_o;
   logic [7:0] rgb_o;
   int checks = 0, errors = 0, cyc = 0;
   int ls[8];
   logic lg_hs[N], lg_vs[N], lg_bl[N];
   logic [7:0] lg_rgb[N];

   scanconvert2_lx45 dut (
      .clk25m(clk25m), .reset(reset), .pix_ce_i(pix_ce_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
      .blank_i(blank_i), .rgb_i(rgb_i), .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o), .rgb_o(rgb_o)
   );

   always #20 clk25m = ~clk25m;
   always @(posedge clk25m) cyc <= cyc + 1;
   always @(negedge clk25m) if (cyc < N) begin
      lg_hs[cyc]  <= hsync_o;
      lg_vs[cyc]  <= vsync_o;
      lg_bl[cyc]  <= blank_o;
      lg_rgb[cyc] <= rgb_o;
   end

   // mode 0 = ramp (pixel index), 1 = AA, 2 = 55; pixels start at strobe 16
   task automatic send_line(input int idx, input int mode, input int npix, input int nstr, input logic vs);
      for (int s = 0; s < nstr; s++) begin
         @(negedge clk25m);
         if (s == 0) ls[idx] = cyc + 1;
         pix_ce_i = 1'b1;
         hsync_i  = (s < 8) ? 1'b0 : 1'b1;
         blank_i  = !(s >= 16 && s < 16 + npix);
         rgb_i    = blank_i ? 8'hEE : (mode == 0) ? 8'(s - 16) : (mode == 1) ? 8'hAA : 8'h55;
         vsync_i  = vs;
         @(negedge clk25m);
         pix_ce_i = 1'b0;
         repeat (2) @(negedge clk25m);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      for (int s = 0; s < 12; s++) begin
         @(negedge clk25m);
         pix_ce_i = 1'b1; hsync_i = s[1]; vsync_i = 1'b0; blank_i = 1'b0; rgb_i = 8'hFF;
         @(negedge clk25m);
         pix_ce_i = 1'b0;
         repeat (2) @(negedge clk25m);
      end
      checks++;
      if ({hsync_o, vsync_o, blank_o, rgb_o} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL reset_now got %b%b%b %h exp 111 00", hsync_o, vsync_o, blank_o, rgb_o);
      end
      for (int t = 1; t < cyc; t++)
         if ({lg_hs[t], lg_vs[t], lg_bl[t], lg_rgb[t]} !== {1'b1, 1'b1, 1'b1, 8'h00}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_hold bad_cycles=%0d exp 0", bad); end
      hsync_i = 1'b1; vsync_i = 1'b1; blank_i = 1'b1;
      @(negedge clk25m);
      reset = 1'b1;
   endtask

   task automatic test_ramp();
      int bad = 0, b;
      vec_t v[15];
      int rel = cyc;
      send_line(0, 0, 256, 400, 1'b1);
      send_line(1, 1, 256, 400, 1'b1);
      b = ls[1];
      for (int t = rel; t <= b + 1; t++)
         if ({lg_hs[t], lg_vs[t], lg_bl[t], lg_rgb[t]} !== {1'b1, 1'b1, 1'b1, 8'h00}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL pre_prime bad_cycles=%0d exp 0", bad); end
      v = '{'{1, 1'b1, 1'b1, 8'h00}, '{2, 1'b0, 1'b1, 8'h00}, '{49, 1'b0, 1'b1, 8'h00},
            '{50, 1'b0, 1'b0, 8'h00}, '{51, 1'b0, 1'b0, 8'h00}, '{52, 1'b0, 1'b0, 8'h01},
            '{97, 1'b0, 1'b0, 8'd23}, '{98, 1'b1, 1'b0, 8'd24}, '{561, 1'b1, 1'b0, 8'hFF},
            '{562, 1'b1, 1'b1, 8'h00}, '{801, 1'b1, 1'b1, 8'h00}, '{802, 1'b0, 1'b1, 8'h00},
            '{850, 1'b0, 1'b0, 8'h00}, '{1361, 1'b1, 1'b0, 8'hFF}, '{1362, 1'b1, 1'b1, 8'h00}};
      foreach (v[i]) begin
         int t = b + v[i].off;
         checks++;
         if ({lg_hs[t], lg_bl[t], lg_rgb[t]} !== {v[i].hs, v[i].bl, v[i].rgb}) begin
            errors++;
            $display("FAIL ramp@%0d got hs=%b bl=%b rgb=%h exp hs=%b bl=%b rgb=%h",
                     v[i].off, lg_hs[t], lg_bl[t], lg_rgb[t], v[i].hs, v[i].bl, v[i].rgb);
         end
      end
      for (int l = 0; l < 2; l++) begin
         bad = 0;
         for (int j = 0; j < 512; j++)
            if (lg_bl[b + 50 + 800 * l + j] !== 1'b0 || lg_rgb[b + 50 + 800 * l + j] !== 8'(j / 2)) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL ramp_line%0d bad_pixels=%0d exp 0", l, bad); end
      end
   endtask

   task automatic test_ping_pong();
      send_line(2, 2, 256, 400, 1'b1);
      send_line(3, 0, 0, 400, 1'b0);
      for (int k = 2; k < 4; k++) begin
         logic [7:0] e = (k == 2) ? 8'hAA : 8'h55;
         int b = ls[k], bad = 0;
         for (int l = 0; l < 2; l++)
            for (int j = 0; j < 512; j++)
               if (lg_bl[b + 50 + 800 * l + j] !== 1'b0 || lg_rgb[b + 50 + 800 * l + j] !== e) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL pingpong_%h bad_pixels=%0d exp 0", e, bad); end
         checks++;
         if ({lg_bl[b + 49], lg_bl[b + 562], lg_rgb[b + 562]} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL pingpong_edges_%h got %b%b %h exp 11 00", e, lg_bl[b + 49], lg_bl[b + 562], lg_rgb[b + 562]);
         end
      end
   endtask

   task automatic test_blank_line();
      int b, bad = 0;
      send_line(4, 0, 256, 400, 1'b0);
      b = ls[4];
      for (int k = 2; k < 1597; k++)
         if (lg_bl[b + k] !== 1'b1 || lg_rgb[b + k] !== 8'h00) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL blank_line bad_cycles=%0d exp 0", bad); end
      checks++;
      if ({lg_hs[b + 2], lg_hs[b + 801], lg_hs[b + 802]} !== 3'b010) begin
         errors++;
         $display("FAIL blank_line_hs got %b%b%b exp 010", lg_hs[b + 2], lg_hs[b + 801], lg_hs[b + 802]);
      end
   endtask

   task automatic test_truncate_vsync();
      int b, bad = 0;
      vec_t v[5];
      send_line(5, 0, 384, 400, 1'b0);
      send_line(6, 0, 600, 700, 1'b1);
      b = ls[6];
      v = '{'{801, 1'b1, 1'b0, 8'd119}, '{802, 1'b0, 1'b1, 8'h00}, '{850, 1'b0, 1'b0, 8'h00},
            '{1617, 1'b1, 1'b0, 8'd127}, '{1618, 1'b1, 1'b1, 8'h00}};
      foreach (v[i]) begin
         int t = b + v[i].off;
         checks++;
         if ({lg_hs[t], lg_bl[t], lg_rgb[t]} !== {v[i].hs, v[i].bl, v[i].rgb}) begin
            errors++;
            $display("FAIL trunc@%0d got hs=%b bl=%b rgb=%h exp hs=%b bl=%b rgb=%h",
                     v[i].off, lg_hs[t], lg_bl[t], lg_rgb[t], v[i].hs, v[i].bl, v[i].rgb);
         end
      end
      checks++;
      if ({lg_vs[ls[3] + 1], lg_vs[ls[3] + 2]} !== 2'b10) begin
         errors++; $display("FAIL vsync_fall got %b%b exp 10", lg_vs[ls[3] + 1], lg_vs[ls[3] + 2]);
      end
      checks++;
      if ({lg_vs[b + 1], lg_vs[b + 2]} !== 2'b01) begin
         errors++; $display("FAIL vsync_rise got %b%b exp 01", lg_vs[b + 1], lg_vs[b + 2]);
      end
      for (int t = ls[3] + 2; t <= b + 1; t++) if (lg_vs[t] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL vsync_span bad_cycles=%0d exp 0", bad); end
   endtask

   task automatic test_overflow();
      int b;
      vec_t v[7];
      send_line(7, 0, 0, 400, 1'b1);
      b = ls[7];
      v = '{'{50, 1'b0, 1'b0, 8'h00}, '{850, 1'b1, 1'b0, 8'd144}, '{1070, 1'b1, 1'b0, 8'd254},
            '{1071, 1'b1, 1'b0, 8'd254}, '{1072, 1'b1, 1'b1, 8'h00}, '{1402, 1'b0, 1'b1, 8'h00},
            '{1450, 1'b0, 1'b0, 8'h00}};
      foreach (v[i]) begin
         int t = b + v[i].off;
         checks++;
         if ({lg_hs[t], lg_bl[t], lg_rgb[t]} !== {v[i].hs, v[i].bl, v[i].rgb}) begin
            errors++;
            $display("FAIL ovf@%0d got hs=%b bl=%b rgb=%h exp hs=%b bl=%b rgb=%h",
                     v[i].off, lg_hs[t], lg_bl[t], lg_rgb[t], v[i].hs, v[i].bl, v[i].rgb);
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk25m);
      #4;
      checks++;
      if (blank_o !== 1'b0) begin errors++; $display("FAIL pre_async_active got bl=%b exp 0", blank_o); end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({hsync_o, vsync_o, blank_o, rgb_o} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL async_reset got %b%b%b %h exp 111 00", hsync_o, vsync_o, blank_o, rgb_o);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_ping_pong();
      test_blank_line();
      test_truncate_vsync();
      test_overflow();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
